// File: rtl/rv_pkg.sv
// Shared RV32 definitions: opcodes, instruction formats and loader error codes.
// Consumed by the decoder, ImmGen, control unit and the instruction encoder/loader.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_FMT  = 2'd1;
  localparam logic [1:0] ERR_IMM  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } ld_state_e;

endpackage

// File: rtl/rv_instr_encoder_loader_if.sv
// Descriptor (valid/ready) and instruction-memory write bus of the loader.
// slave = loader side, master = descriptor source / memory model side.
interface rv_instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  in_valid, in_fmt, in_opcode,
    input  in_rd, in_rs1, in_rs2,
    input  in_funct3, in_funct7,
    input  in_imm, in_last, mem_ready,
    output in_ready, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_fmt, in_opcode,
    output in_rd, in_rs1, in_rs2,
    output in_funct3, in_funct7,
    output in_imm, in_last, mem_ready,
    input  in_ready, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv_field_packer.sv
// Packs decoded fields into a 32-bit RV instruction word
// and flags illegal formats or unencodable immediates.
module rv_field_packer
  import rv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        fmt_ok,
  output logic        range_ok
);

  // imm fits in N signed bits when bits [31:N-1] are all equal
  logic fits12, fits13, fits21;
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    word     = '0;
    fmt_ok   = 1'b1;
    range_ok = 1'b1;
    unique case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word     = {imm[11:0], rs1, funct3, rd, opcode};
        range_ok = fits12;
      end
      FMT_S: begin
        word     = {imm[11:5], rs2, rs1, funct3,
                    imm[4:0], opcode};
        range_ok = fits12;
      end
      FMT_B: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3,
                    imm[4:1], imm[11], opcode};
        range_ok = fits13 & ~imm[0];
      end
      FMT_U: begin
        word     = {imm[31:12], rd, opcode};
        range_ok = ~(|imm[11:0]);
      end
      FMT_J: begin
        word     = {imm[20], imm[10:1], imm[11],
                    imm[19:12], rd, opcode};
        range_ok = fits21 & ~imm[0];
      end
      default: fmt_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_instr_encoder_loader.sv
// Test-program loader: encodes descriptors and writes them
// to instruction memory at consecutive word addresses.
module rv_instr_encoder_loader
  import rv_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  rv_instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [ADDR_W:0]       count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  ld_state_e       state, state_d;
  logic [31:0]     wdata_q;
  logic            last_q;
  logic [31:0]     word;
  logic            fmt_ok, range_ok;
  logic            accept, wr_hs, restart;
  logic [ADDR_W:0] count_inc;

  rv_field_packer u_packer (
    .fmt      (bus.in_fmt),
    .opcode   (bus.in_opcode),
    .rd       (bus.in_rd),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .funct3   (bus.in_funct3),
    .funct7   (bus.in_funct7),
    .imm      (bus.in_imm),
    .word     (word),
    .fmt_ok   (fmt_ok),
    .range_ok (range_ok)
  );

  assign accept    = (state == ST_LOAD) & bus.in_valid;
  assign wr_hs     = (state == ST_WRITE) & bus.mem_ready;
  assign restart   = start &
                     ((state == ST_IDLE) | (state == ST_ERROR));
  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (bus.in_valid)
          state_d = (fmt_ok & range_ok) ? ST_WRITE : ST_ERROR;
      end
      ST_WRITE: begin
        if (bus.mem_ready) begin
          if (last_q)                    state_d = ST_DONE;
          else if (count_inc == DEPTH_C) state_d = ST_ERROR;
          else                           state_d = ST_LOAD;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: if (start) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdata_q  <= '0;
      last_q   <= 1'b0;
      count    <= '0;
      err_code <= ERR_NONE;
    end else begin
      if (restart) begin
        count    <= '0;
        err_code <= ERR_NONE;
      end
      if (accept) begin
        wdata_q <= word;
        last_q  <= bus.in_last;
        if (!fmt_ok)        err_code <= ERR_FMT;
        else if (!range_ok) err_code <= ERR_IMM;
      end
      if (wr_hs) begin
        count <= count_inc;
        if (!last_q && count_inc == DEPTH_C)
          err_code <= ERR_OVF;
      end
    end
  end

  // address tracks count; overflow stops the session before wrap
  assign bus.mem_addr  = count[ADDR_W-1:0];
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state == ST_WRITE);
  assign bus.in_ready  = (state == ST_LOAD);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign err           = (state == ST_ERROR);

endmodule
